// File: rtl/z_reg.sv
// Registered zero flag for a WIDTH-bit data word.
// Ports: clk, rstN (async low), dataIn, wrEn, Zout (flag flop).
module z_reg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             wrEn,
  output logic             Zout
);

  logic zero;

  assign zero = ~|dataIn;

  // Zout comes straight from this flop; no bypass from dataIn.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      Zout <= 1'b0;
    end else if (wrEn) begin
      Zout <= zero;
    end
  end

endmodule

// File: tb/tb_z_reg.sv
// Self-checking bench for z_reg.
// Directed scenarios plus a random run against a behavioural model.
module tb_z_reg;

  localparam int W = 12;

  logic         clk;
  logic         rstN;
  logic [W-1:0] dataIn;
  logic         wrEn;
  logic         Zout;

  int checks = 0;
  int errors = 0;

  z_reg #(.WIDTH(W)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .dataIn (dataIn),
    .wrEn   (wrEn),
    .Zout   (Zout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic r, input logic w, input logic [W-1:0] d);
    @(negedge clk);
    rstN   = r;
    wrEn   = w;
    dataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstN   = 1'b0;
    wrEn   = 1'b1;
    dataIn = '0;
    #1;
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Zout=%b expected 0", Zout);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (Zout !== 1'b0) begin
        errors++;
        $display("FAIL reset_priority[%0d]: Zout=%b expected 0", i, Zout);
      end
    end
  endtask

  task automatic test_zero_write;
    cycle(1'b1, 1'b0, '0);
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL no_write_after_reset: Zout=%b expected 0", Zout);
    end
    cycle(1'b1, 1'b1, 12'h000);
    checks++;
    if (Zout !== 1'b1) begin
      errors++;
      $display("FAIL write_zero: Zout=%b expected 1", Zout);
    end
  endtask

  task automatic test_single_bits;
    logic [W-1:0] d;
    cycle(1'b1, 1'b1, 12'h004);
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL write_004: Zout=%b expected 0", Zout);
    end
    cycle(1'b1, 1'b1, 12'h800);
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL write_800: Zout=%b expected 0", Zout);
    end
    cycle(1'b1, 1'b1, 12'h001);
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL write_001: Zout=%b expected 0", Zout);
    end
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, 1'b1, '0);
      checks++;
      if (Zout !== 1'b1) begin
        errors++;
        $display("FAIL bit_pre[%0d]: Zout=%b expected 1", i, Zout);
      end
      d = '0;
      d[i] = 1'b1;
      cycle(1'b1, 1'b1, d);
      checks++;
      if (Zout !== 1'b0) begin
        errors++;
        $display("FAIL bit[%0d]: Zout=%b expected 0", i, Zout);
      end
    end
  endtask

  task automatic test_hold;
    cycle(1'b1, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 12'hFFF);
      checks++;
      if (Zout !== 1'b1) begin
        errors++;
        $display("FAIL hold_one[%0d]: Zout=%b expected 1", i, Zout);
      end
    end
    cycle(1'b1, 1'b0, 'x);
    checks++;
    if (Zout !== 1'b1) begin
      errors++;
      $display("FAIL hold_x_data: Zout=%b expected 1", Zout);
    end
    cycle(1'b1, 1'b1, 12'h3A0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0);
      checks++;
      if (Zout !== 1'b0) begin
        errors++;
        $display("FAIL hold_zero[%0d]: Zout=%b expected 0", i, Zout);
      end
    end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, 1'b1, '0);
    checks++;
    if (Zout !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: Zout=%b expected 1", Zout);
    end
    #1;
    rstN = 1'b0;
    #1;
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL midcycle_clear: Zout=%b expected 0", Zout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL held_in_reset: Zout=%b expected 0", Zout);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if (Zout !== 1'b0) begin
      errors++;
      $display("FAIL after_release: Zout=%b expected 0", Zout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Zout !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_after_reset: Zout=%b expected 1", Zout);
    end
  endtask

  task automatic test_back_to_back;
    logic exp;
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 0) ? W'(0) : W'($urandom_range(1, (1 << W) - 1));
      exp = (d == 0);
      cycle(1'b1, 1'b1, d);
      checks++;
      if (Zout !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] d=%h: Zout=%b expected %b", i, d, Zout, exp);
      end
    end
  endtask

  task automatic test_random;
    logic model;
    logic r;
    logic w;
    logic [W-1:0] d;
    model = Zout;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 7) != 0);
      w = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = W'(1) << $urandom_range(0, W - 1);
        default: d = W'($urandom);
      endcase
      cycle(r, w, d);
      if (!r) model = 1'b0;
      else if (w) model = (d == 0);
      checks++;
      if (Zout !== model) begin
        errors++;
        $display("FAIL random[%0d] r=%b w=%b d=%h: Zout=%b expected %b",
                 i, r, w, d, Zout, model);
      end
    end
  endtask

  initial begin
    rstN   = 1'b0;
    wrEn   = 1'b0;
    dataIn = '0;
    test_reset();
    test_zero_write();
    test_single_bits();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
